// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and write sequencer feeding a UART transmitter
module uart_tx_fifo #(
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3,
   parameter int BUSY_TO = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              flush,
   input  logic              Tx_EN,
   input  logic              Tx_BUSY,
   output logic [7:0]        Tx_DATA,
   output logic              Tx_WR,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              tx_timeout
);

   localparam int TIMER_W = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   logic [7:0]         mem [DEPTH];

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  wptr_q, wptr_d;
   logic [ADDR_W-1:0]  rptr_q, rptr_d;
   logic [ADDR_W:0]    count_q, count_d;
   logic               in_ready_q, in_ready_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_wr_q, tx_wr_d;
   logic               overflow_q, overflow_d;
   logic               tx_timeout_q, tx_timeout_d;
   logic [TIMER_W-1:0] timer_q, timer_d;

   logic               push;
   logic               pop;
   logic               timeout_hit;

   // A flush wins over a push on the same edge, so the byte is simply lost.
   assign push = in_valid && in_ready_q && !flush;

   // Next-state logic: sequencer, pointers, occupancy and sticky flags.
   always_comb begin
      state_d      = state_q;
      tx_data_d    = tx_data_q;
      timer_d      = timer_q;
      pop          = 1'b0;
      timeout_hit  = 1'b0;

      case (state_q)
         IDLE: begin
            // Tx_DATA is loaded from the FIFO head only here, so it stays a pure register output.
            if (!flush && Tx_EN && (count_q != '0) && !Tx_BUSY) begin
               state_d   = ISSUE;
               tx_data_d = mem[rptr_q];
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = flush ? IDLE : WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else if (Tx_BUSY) begin
               // The transmitter has taken the byte; only now does it leave the FIFO.
               pop     = 1'b1;
               state_d = WAIT_DONE;
            end else if (timer_q == TIMER_W'(BUSY_TO - 1)) begin
               // No response: leave the byte at the head so IDLE reissues it.
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         WAIT_DONE: begin
            // A frame already on the line is never aborted, flush or not.
            if (!Tx_BUSY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      tx_wr_d      = (state_d == ISSUE);

      wptr_d       = flush ? '0 : wptr_q + ADDR_W'(push);
      rptr_d       = flush ? '0 : rptr_q + ADDR_W'(pop);
      count_d      = flush ? '0 : count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      in_ready_d   = (count_d != (ADDR_W+1)'(DEPTH));

      overflow_d   = flush ? 1'b0 : (overflow_q | (in_valid && !in_ready_q));
      tx_timeout_d = flush ? 1'b0 : (tx_timeout_q | timeout_hit);
   end

   // Control and status registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         in_ready_q   <= 1'b1;
         tx_data_q    <= 8'h00;
         tx_wr_q      <= 1'b0;
         overflow_q   <= 1'b0;
         tx_timeout_q <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
         in_ready_q   <= in_ready_d;
         tx_data_q    <= tx_data_d;
         tx_wr_q      <= tx_wr_d;
         overflow_q   <= overflow_d;
         tx_timeout_q <= tx_timeout_d;
         timer_q      <= timer_d;
      end
   end

   // FIFO storage; contents need no reset because occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q] <= in_data;
      end
   end

   assign in_ready   = in_ready_q;
   assign Tx_DATA    = tx_data_q;
   assign Tx_WR      = tx_wr_q;
   assign count      = count_q;
   assign overflow   = overflow_q;
   assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a queue-based reference model
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       flush;
   logic       Tx_EN;
   logic       Tx_BUSY = 1'b0;
   logic [7:0] Tx_DATA;
   logic       Tx_WR;
   logic [3:0] count;
   logic       overflow;
   logic       tx_timeout;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(8), .ADDR_W(3), .BUSY_TO(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .flush      (flush),
      .Tx_EN      (Tx_EN),
      .Tx_BUSY    (Tx_BUSY),
      .Tx_DATA    (Tx_DATA),
      .Tx_WR      (Tx_WR),
      .count      (count),
      .overflow   (overflow),
      .tx_timeout (tx_timeout)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state: FIFO contents as a queue plus transaction bookkeeping.
   logic [7:0] m_q[$];
   bit         m_ovf = 0;
   bit         m_to = 0;
   bit         m_pend = 0;
   int         m_wait = 0;
   logic       wr_s = 1'b0;
   logic       wr_prev = 1'b0;
   logic       en_at_edge = 1'b0;
   logic       busy_at_edge = 1'b0;
   int         wr_pulses = 0;
   logic [7:0] rx[$];
   int         stall = 0;

   // Transmitter model configuration.
   bit tx_resp = 1;
   bit tx_rand = 0;
   int tx_delay = 1;
   int tx_len = 3;

   logic [7:0] pat3 [4] = '{8'hAA, 8'h55, 8'hCC, 8'h89};

   // Reference model, advanced on each rising edge from the inputs seen at that edge.
   initial begin
      bit full;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_q.delete();
            m_ovf = 0; m_to = 0; m_pend = 0; m_wait = 0;
         end else begin
            en_at_edge   = Tx_EN;
            busy_at_edge = Tx_BUSY;
            if (flush) begin
               m_q.delete();
               m_ovf = 0; m_to = 0; m_pend = 0; m_wait = 0;
            end else begin
               full = (m_q.size() == 8);
               if (wr_s) begin
                  m_pend = 1; m_wait = 0;
               end else if (m_pend) begin
                  if (Tx_BUSY) begin
                     if (m_q.size() > 0) void'(m_q.pop_front());
                     m_pend = 0;
                  end else if (m_wait == 15) begin
                     m_to = 1; m_pend = 0;
                  end else begin
                     m_wait++;
                  end
               end
               if (in_valid) begin
                  if (!full) m_q.push_back(in_data);
                  else m_ovf = 1;
               end
            end
         end
      end
   end

   // Compare process: outputs against the model every cycle, away from the rising edge.
   initial begin
      bit elig;
      forever begin
         @(negedge clk);
         if (!reset) begin
            wr_s = 1'b0; wr_prev = 1'b0; stall = 0;
         end else begin
            wr_prev = wr_s;
            wr_s    = Tx_WR;
            chk("count", count, m_q.size());
            chk("in_ready", in_ready, (m_q.size() != 8));
            chk("overflow", overflow, m_ovf);
            chk("tx_timeout", tx_timeout, m_to);
            if (Tx_WR) begin
               chk("wr_one_cycle", wr_prev, 1'b0);
               chk("wr_busy_low", busy_at_edge, 1'b0);
               chk("wr_enabled", en_at_edge, 1'b1);
               chk("wr_nonempty", (m_q.size() > 0), 1'b1);
               if (m_q.size() > 0) chk("tx_data_head", Tx_DATA, m_q[0]);
               wr_pulses++;
               rx.push_back(Tx_DATA);
            end
            elig = (m_q.size() > 0) && Tx_EN && !Tx_BUSY && !m_pend && !Tx_WR;
            stall = elig ? stall + 1 : 0;
            chk("issue_stall", (stall > 3), 1'b0);
         end
      end
   end

   // Transmitter model: raises Tx_BUSY some cycles after a write strobe and holds it a while.
   initial begin
      int rise_cnt = 0;
      int busy_left = 0;
      int cur_len = 1;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            rise_cnt = 0; busy_left = 0; Tx_BUSY = 1'b0;
         end else begin
            if (busy_left > 0) begin
               busy_left--;
               if (busy_left == 0) Tx_BUSY = 1'b0;
            end
            if (rise_cnt > 0) begin
               rise_cnt--;
               if (rise_cnt == 0) begin
                  Tx_BUSY = 1'b1;
                  busy_left = cur_len;
               end
            end
            if (Tx_WR && tx_resp) begin
               if (tx_rand) begin
                  if ($urandom_range(9) != 0) begin
                     rise_cnt = $urandom_range(4, 1);
                     cur_len  = $urandom_range(8, 1);
                  end
               end else begin
                  rise_cnt = tx_delay;
                  cur_len  = tx_len;
               end
            end
         end
      end
   end

   task automatic push_one(input logic [7:0] b);
      @(negedge clk);
      #2 in_valid = 1'b1;
      in_data = b;
   endtask

   task automatic push_end();
      @(negedge clk);
      #2 in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget, input int base_rx, input int n);
      bit done = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (count == 0 && !Tx_BUSY && rx.size() >= base_rx + n) begin
            done = 1;
            break;
         end
      end
      chk(name, done, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      int base_wr;
      int base_rx;
      int lat;
      bit found;

      reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; Tx_EN = 1'b0;

      // Reset held for three clocks.
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_tx_wr", Tx_WR, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_tx_timeout", tx_timeout, 1'b0);
      chk("rst_tx_data", Tx_DATA, 8'h00);
      #2 reset = 1'b1;

      // Single byte: latency, one strobe, pop on the busy edge.
      Tx_EN = 1'b1; tx_resp = 1; tx_rand = 0; tx_delay = 1; tx_len = 100;
      base_wr = wr_pulses;
      @(negedge clk);
      #2 in_valid = 1'b1; in_data = 8'hAA;
      @(negedge clk);
      chk("t2_wr_not_yet", Tx_WR, 1'b0);
      chk("t2_count_1", count, 1);
      #2 in_valid = 1'b0;
      @(negedge clk);
      chk("t2_wr_pulse", Tx_WR, 1'b1);
      chk("t2_tx_data", Tx_DATA, 8'hAA);
      @(negedge clk);
      chk("t2_count_before_busy", count, 1);
      @(negedge clk);
      chk("t2_count_after_busy", count, 0);
      chk("t2_busy_seen", Tx_BUSY, 1'b1);
      repeat (110) @(negedge clk);
      chk("t2_one_pulse", wr_pulses - base_wr, 1);
      chk("t2_data_held", Tx_DATA, 8'hAA);

      // Ordering of four back-to-back bytes.
      tx_len = 3;
      base_wr = wr_pulses;
      base_rx = rx.size();
      for (int i = 0; i < 4; i++) push_one(pat3[i]);
      push_end();
      wait_drain("t3_drain", 200, base_rx, 4);
      if (rx.size() >= base_rx + 4)
         for (int i = 0; i < 4; i++) chk("t3_order", rx[base_rx + i], pat3[i]);
      chk("t3_pulses", wr_pulses - base_wr, 4);

      // Full and overflow with the transmitter disabled.
      @(negedge clk);
      #2 Tx_EN = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i == 8) begin
            chk("t4_full_in_ready", in_ready, 1'b0);
            chk("t4_full_count", count, 8);
         end
         #2 in_valid = 1'b1;
         in_data = 8'(16 + i);
      end
      @(negedge clk);
      chk("t4_overflow", overflow, 1'b1);
      chk("t4_count_8", count, 8);
      #2 in_valid = 1'b0;
      base_rx = rx.size();
      Tx_EN = 1'b1;
      wait_drain("t4_drain", 400, base_rx, 8);
      if (rx.size() >= base_rx + 8)
         for (int i = 0; i < 8; i++) chk("t4_drain_order", rx[base_rx + i], 8'(16 + i));

      // Timeout and reissue of the same byte.
      @(negedge clk);
      #2 flush = 1'b1;
      @(negedge clk);
      chk("t5_flush_ovf_clr", overflow, 1'b0);
      #2 flush = 1'b0;
      tx_resp = 0;
      push_one(8'h3C);
      push_end();
      found = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (Tx_WR) begin found = 1; break; end
      end
      chk("t5_first_wr", found, 1'b1);
      lat = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (tx_timeout) begin lat = k; break; end
      end
      chk("t5_timeout_latency", lat, 17);
      #1 tx_resp = 1;
      @(negedge clk);
      chk("t5_reissue_wr", Tx_WR, 1'b1);
      chk("t5_reissue_data", Tx_DATA, 8'h3C);
      chk("t5_count_kept", count, 1);
      wait_drain("t5_drain", 100, 0, 0);
      @(negedge clk);
      #2 flush = 1'b1;
      @(negedge clk);
      chk("t5_flush_to_clr", tx_timeout, 1'b0);
      #2 flush = 1'b0;

      // Flush while a frame is on the line.
      tx_delay = 1; tx_len = 20;
      push_one(8'hA1); push_one(8'hA2); push_one(8'hA3);
      push_end();
      found = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (Tx_BUSY && count == 2) begin found = 1; break; end
      end
      chk("t6_in_wait_done", found, 1'b1);
      #2 flush = 1'b1;
      @(negedge clk);
      chk("t6_flush_count", count, 0);
      chk("t6_still_busy", Tx_BUSY, 1'b1);
      #2 flush = 1'b0;
      base_wr = wr_pulses;
      found = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!Tx_BUSY) begin found = 1; break; end
      end
      chk("t6_busy_fell", found, 1'b1);
      repeat (10) @(negedge clk);
      chk("t6_no_more_wr", wr_pulses - base_wr, 0);

      // Asynchronous reset while a strobe is high.
      tx_len = 3;
      push_one(8'h77);
      push_end();
      found = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (Tx_WR) begin found = 1; break; end
      end
      chk("t6_issue_seen", found, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("t6_async_wr_drop", Tx_WR, 1'b0);
      chk("t6_async_count", count, 0);
      chk("t6_async_in_ready", in_ready, 1'b1);
      chk("t6_async_tx_data", Tx_DATA, 8'h00);
      @(negedge clk);
      #2 reset = 1'b1;

      // Randomized traffic: light then heavy producer, random enable, flushes and responses.
      tx_rand = 1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         #2;
         in_valid = (c < 2000) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
         in_data  = 8'($urandom);
         flush    = ($urandom_range(149) == 0);
         if ($urandom_range(59) == 0) Tx_EN = ~Tx_EN;
      end
      in_valid = 1'b0;
      flush = 1'b0;
      Tx_EN = 1'b1;
      tx_rand = 0; tx_resp = 1; tx_delay = 1; tx_len = 2;
      wait_drain("rand_drain", 500, 0, 0);
      chk("rand_final_count", count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
